// File: rtl/mem_entry_ctrl.sv
// mem_entry_ctrl: front-panel entry for CPU address latch and data RAM.
// Syncs/debounces btn_addr and btn_write, latches addr/data from sw_in,
// one wr_en pulse per write press. Optional AUTO_INC_EN: addr+1 after write.
// Ports: clk, rst (async high), btn_addr, btn_write, sw_in -> addr,
// data_out, wr_en, busy.
module mem_entry_ctrl #(
  parameter int unsigned WORD_SIZE       = 8,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_addr,
  input  logic                  btn_write,
  input  logic [WORD_SIZE-1:0]  sw_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  wr_en,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // index 0: address button, index 1: write button
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [CW-1:0] cnt [2];
  logic          addr_press;
  logic          wr_press;

  state_t                  state;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [WORD_SIZE-1:0]    data_d;

  assign raw = {btn_write, btn_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_q  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] != deb[b]) begin
          // toggle on the edge the count would reach DEBOUNCE_CYCLES
          if (cnt[b] == CNT_LAST) begin
            deb[b] <= ~deb[b];
            cnt[b] <= '0;
          end else begin
            cnt[b] <= cnt[b] + CW'(1);
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  assign addr_press = deb[0] & ~deb_q[0];
  assign wr_press   = deb[1] & ~deb_q[1];

  always_comb begin
    state_d = state;
    addr_d  = addr;
    data_d  = data_out;
    unique case (state)
      IDLE: begin
        if (addr_press) begin
          addr_d = sw_in[ADDR_WIDTH-1:0];
        end else if (wr_press) begin
          data_d  = sw_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = WAIT_REL;
`ifdef AUTO_INC_EN
        addr_d = addr + ADDR_WIDTH'(1);
        if (addr_press) begin
          addr_d = sw_in[ADDR_WIDTH-1:0];
        end
`endif
      end
      WAIT_REL: begin
        if (!deb[1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs registered from the next state so they track state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      data_out <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      data_out <= data_d;
      wr_en    <= (state_d == WRITE);
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_entry_ctrl.sv
// tb_mem_entry_ctrl: self-checking bench for mem_entry_ctrl.
// Table scenarios, latency/reset sequences and random stimulus vs. a model.
module tb_mem_entry_ctrl;

  localparam int D = 16;
`ifdef AUTO_INC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic       clk;
  logic       rst;
  logic       btn_addr;
  logic       btn_write;
  logic [7:0] sw_in;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       wr_en;
  logic       busy;

  mem_entry_ctrl #(
    .WORD_SIZE(8),
    .ADDR_WIDTH(8),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_addr(btn_addr),
    .btn_write(btn_write),
    .sw_in(sw_in),
    .addr(addr),
    .data_out(data_out),
    .wr_en(wr_en),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [7:0] wr_addrs [$];

  // reference model: window-based debounce, spec-level entry rules
  bit         m_s1 [2];
  bit         m_s2 [2];
  bit         m_deb [2];
  bit         m_prev [2];
  bit [D-1:0] m_win [2];
  int         m_fill [2];
  int         m_st;
  logic [7:0] m_addr;
  logic [7:0] m_data;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_prev[b] = 0;
      m_win[b] = '0; m_fill[b] = 0;
    end
    m_st = 0; m_addr = 8'h00; m_data = 8'h00;
  endfunction

  function automatic void model_step(input bit ra, input bit rw,
                                     input logic [7:0] sw);
    bit pa, pw;
    int nst;
    logic [7:0] na, nd;
    bit ndeb [2];
    bit [D-1:0] ones;
    pa = m_deb[0] && !m_prev[0];
    pw = m_deb[1] && !m_prev[1];
    nst = m_st; na = m_addr; nd = m_data;
    if (m_st == 0) begin
      if (pa) na = sw;
      else if (pw) begin nd = sw; nst = 1; end
    end else if (m_st == 1) begin
      nst = 2;
      if (INC == 1) begin
        na = 8'((int'(m_addr) + 1) % 256);
        if (pa) na = sw;
      end
    end else if (!m_deb[1]) begin
      nst = 0;
    end
    ones = '1;
    for (int b = 0; b < 2; b++) begin
      m_win[b] = {m_win[b][D-2:0], m_s2[b]};
      if (m_fill[b] < D) m_fill[b]++;
      ndeb[b] = m_deb[b];
      // level flips once the last D synced samples all disagree with it
      if (m_fill[b] == D && m_win[b] == (m_deb[b] ? '0 : ones))
        ndeb[b] = !m_deb[b];
    end
    for (int b = 0; b < 2; b++) begin
      m_prev[b] = m_deb[b];
      m_deb[b]  = ndeb[b];
      m_s2[b]   = m_s1[b];
    end
    m_s1[0] = ra; m_s1[1] = rw;
    m_st = nst; m_addr = na; m_data = nd;
  endfunction

  // one clock: model steps at the edge, DUT checked at the next negedge
  task automatic tick();
    bit ra, rw;
    logic [7:0] sw;
    ra = btn_addr; rw = btn_write; sw = sw_in;
    @(posedge clk);
    model_step(ra, rw, sw);
    @(negedge clk);
    chk("model", {addr, data_out, wr_en, busy},
        {m_addr, m_data, (m_st == 1), (m_st != 0)});
    if (wr_en) begin
      wr_cnt++;
      wr_addrs.push_back(addr);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    btn_addr = 0; btn_write = 0;
    rst = 1;
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_data", data_out, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    int         a_len;
    int         w_len;
    logic [7:0] sw;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    int         e_wr;
  } vec_t;

  vec_t vt [6];

  initial begin
    int got;
    int seg;
    rst = 1; btn_addr = 0; btn_write = 0; sw_in = 8'h00;
    @(negedge clk);
    do_reset();

    // address load latency
    sw_in = 8'h3C; btn_addr = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == D + 2) chk("addr_lat_pre", addr, 8'h00);
      if (i == D + 3) chk("addr_lat", addr, 8'h3C);
    end
    btn_addr = 0;
    ticks(30);
    chk("addr_no_wr", wr_cnt, 0);

    // write latency and single pulse
    sw_in = 8'hA5; btn_write = 1; wr_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == D + 2) chk("wr_lat_pre", wr_en, 0);
      if (i == D + 3) chk("wr_lat", wr_en, 1);
      if (i == D + 4) chk("wr_lat_post", wr_en, 0);
      if (i == D + 4) chk("wr_busy", busy, 1);
    end
    chk("wr_data", data_out, 8'hA5);
    btn_write = 0;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      if (i == D + 2) chk("rel_busy_hold", busy, 1);
      if (i == D + 3) chk("rel_busy_drop", busy, 0);
    end
    ticks(10);
    chk("wr_once", wr_cnt, 1);

    vt[0] = '{0, 1,  8'h11, 8'(8'h3C + INC), 8'hA5, 0};
    vt[1] = '{0, 5,  8'h22, 8'(8'h3C + INC), 8'hA5, 0};
    vt[2] = '{0, 15, 8'h33, 8'(8'h3C + INC), 8'hA5, 0};
    vt[3] = '{25, 25, 8'h07, 8'h07, 8'hA5, 0};
    vt[4] = '{0, 30, 8'h5A, 8'(8'h07 + INC), 8'h5A, 1};
    vt[5] = '{20, 0, 8'h80, 8'h80, 8'h5A, 0};
    for (int v = 0; v < 6; v++) begin
      wr_cnt = 0;
      sw_in = vt[v].sw;
      for (int i = 0; i < 40; i++) begin
        btn_addr  = (i < vt[v].a_len);
        btn_write = (i < vt[v].w_len);
        tick();
      end
      btn_addr = 0; btn_write = 0;
      ticks(D + 10);
      chk($sformatf("vec%0d_addr", v), addr, vt[v].e_addr);
      chk($sformatf("vec%0d_data", v), data_out, vt[v].e_data);
      chk($sformatf("vec%0d_wr", v), wr_cnt, vt[v].e_wr);
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end

    // reset while the write strobe is high
    sw_in = 8'hC3; btn_write = 1;
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      tick();
      if (wr_en) got = 1;
    end
    chk("midwr_seen", got, 1);
    btn_write = 0;
    do_reset();
    ticks(5);
    chk("midwr_idle", busy, 0);

    // auto-increment wrap across two writes
    sw_in = 8'hFF; btn_addr = 1; ticks(20);
    btn_addr = 0; ticks(30);
    wr_addrs.delete(); wr_cnt = 0;
    sw_in = 8'h11; btn_write = 1; ticks(20);
    btn_write = 0; ticks(30);
    sw_in = 8'h22; btn_write = 1; ticks(20);
    btn_write = 0; ticks(30);
    chk("inc_wr_cnt", wr_cnt, 2);
    if (wr_addrs.size() == 2) begin
      chk("inc_wr0", wr_addrs[0], 8'hFF);
      chk("inc_wr1", wr_addrs[1], (INC == 1) ? 8'h00 : 8'hFF);
    end
    chk("inc_final", addr, (INC == 1) ? 8'h01 : 8'hFF);

    // random button activity against the model
    seg = 0;
    while (seg < 150) begin
      btn_addr  = ($urandom_range(0, 3) == 0);
      btn_write = ($urandom_range(0, 2) == 0);
      sw_in     = 8'($urandom);
      ticks($urandom_range(1, 40));
      seg++;
    end
    btn_addr = 0; btn_write = 0;
    ticks(D + 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
